// File: rtl/trv_pkg.sv
// Shared definitions for the writeback path: register address width,
// writeback source encoding and the default ALU result queue depth.
package trv_pkg;

  localparam int REG_ADDR_W          = 5;
  localparam int DEFAULT_ALU_Q_DEPTH = 2;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2
  } wb_src_e;

endpackage

// File: rtl/sync_fifo.sv
// Small in-order FIFO with asynchronous active-high reset. A push and a pop
// may land in the same cycle, including when the FIFO is full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the simultaneous push writes into, so full is no obstacle then.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates load responses and queued ALU results onto the
// register file write port, and tracks outstanding loads for decode hazards.
module writeback_unit
  import trv_pkg::*;
#(
  parameter int B_WIDTH     = 32,
  parameter int ALU_Q_DEPTH = DEFAULT_ALU_Q_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [B_WIDTH-1:0]    alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [B_WIDTH-1:0]    ld_data,
  input  logic                  ld_issue_valid,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  stall,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [B_WIDTH-1:0]    rd_data,
  output logic [1:0]            wb_src,
  output logic                  pending_err
);

  localparam int EW = REG_ADDR_W + B_WIDTH;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [EW-1:0]         fifo_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [B_WIDTH-1:0]    head_data;

  logic                  ld_xfer;
  logic                  alu_xfer;

  wb_src_e               grant_src;
  logic [REG_ADDR_W-1:0] grant_rd;
  logic [B_WIDTH-1:0]    grant_data;

  logic                  write_en_q, write_en_d;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [B_WIDTH-1:0]    rd_data_q;
  wb_src_e               wb_src_q;

  logic [31:0]           pending_q, pending_d;
  logic                  pending_err_q, pending_err_d;

  assign ld_ready  = ~rst;
  assign alu_ready = ~rst & ~fifo_full;
  assign ld_xfer   = ld_valid & ld_ready;
  assign alu_xfer  = alu_valid & alu_ready;

  assign {head_rd, head_data} = fifo_head;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (ALU_Q_DEPTH)
  ) u_alu_q (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({alu_rd, alu_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Fixed priority: load, then oldest queued ALU result, then ALU bypass.
  always_comb begin
    grant_src  = WB_NONE;
    grant_rd   = '0;
    grant_data = '0;
    fifo_pop   = 1'b0;
    fifo_push  = alu_xfer;
    if (ld_xfer) begin
      grant_src  = WB_LOAD;
      grant_rd   = ld_rd;
      grant_data = ld_data;
    end else if (!fifo_empty) begin
      grant_src  = WB_ALU;
      grant_rd   = head_rd;
      grant_data = head_data;
      fifo_pop   = 1'b1;
    end else if (alu_xfer) begin
      grant_src  = WB_ALU;
      grant_rd   = alu_rd;
      grant_data = alu_data;
      fifo_push  = 1'b0;
    end
  end

  assign write_en_d = (grant_src != WB_NONE) && (grant_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      wb_src_q   <= WB_NONE;
    end else begin
      write_en_q <= write_en_d;
      rd_addr_q  <= grant_rd;
      rd_data_q  <= grant_data;
      wb_src_q   <= grant_src;
    end
  end

  assign write_en = write_en_q;
  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign wb_src   = wb_src_q;

  // Clear is applied before set so a same-cycle issue to the same rd wins.
  always_comb begin
    pending_d     = pending_q;
    pending_err_d = pending_err_q;
    if (ld_xfer) begin
      if (!pending_q[ld_rd]) pending_err_d = 1'b1;
      pending_d[ld_rd] = 1'b0;
    end
    if (ld_issue_valid && (ld_issue_rd != '0)) begin
      if (pending_q[ld_issue_rd]) pending_err_d = 1'b1;
      pending_d[ld_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q     <= '0;
      pending_err_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      pending_err_q <= pending_err_d;
    end
  end

  assign stall       = pending_q[rs1_addr] | pending_q[rs2_addr];
  assign pending_err = pending_err_q;

endmodule
